// File: rtl/modn_counter.sv
// Modulo-MOD up/down counter with load, enable, one-shot stop and cascade tc.
// Optional wrap event counter is built when MODN_COUNTER_WRAPCNT_EN is defined.
module modn_counter #(
  parameter int WIDTH = 6,
  parameter int MOD   = 47
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err,
  output logic [15:0]      wrap_cnt
);

  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("modn_counter: WIDTH must be in 1..31");
  end
  if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("modn_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic       ST_RUN  = 1'b0;
  localparam logic       ST_DONE = 1'b1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;
  logic             at_term;

  assign load_ok = (32'(load_val) < 32'(MOD));
  assign at_term = up_dn ? (count_q == MAX_VAL) : (count_q == '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = done_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_val;
        state_d = ST_RUN;
        done_d  = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en && state_q == ST_RUN) begin
      // At the terminal value either stop (one-shot) or wrap within 0..MOD-1.
      if (at_term) begin
        if (one_shot) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          count_d = up_dn ? '0 : MAX_VAL;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef MODN_COUNTER_WRAPCNT_EN
  logic [15:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (load && load_ok) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && wrap_cnt_q != 16'hFFFF) begin
      wrap_cnt_d = wrap_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = '0;
`endif

  assign count    = count_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = en & (state_q == ST_RUN) & at_term;

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboard bench for modn_counter (WIDTH=6, MOD=47): the driver queues the
// expected post-edge outputs and a monitor compares them after each edge.
module tb_modn_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load, up_dn, one_shot;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       tc, wrap, done, load_err;
  logic [15:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   count;
    logic done;
    logic wrap;
    logic lerr;
    logic tc;
    int   wc;
  } exp_t;

  exp_t exp_q[$];

  modn_counter #(.WIDTH(6), .MOD(47)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .one_shot(one_shot), .count(count), .tc(tc), .wrap(wrap),
    .done(done), .load_err(load_err), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int expWc(input int v);
`ifdef MODN_COUNTER_WRAPCNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the outputs
  // expected just after the following rising edge.
  task automatic applyStimulus(input logic i_en, input logic i_load,
                               input int i_val, input logic i_up,
                               input logic i_os, input int e_count,
                               input logic e_done, input logic e_wrap,
                               input logic e_lerr, input logic e_tc,
                               input int e_wc);
    exp_t e;
    @(negedge clk);
    en       = i_en;
    load     = i_load;
    load_val = 6'(i_val);
    up_dn    = i_up;
    one_shot = i_os;
    e.count = e_count;
    e.done  = e_done;
    e.wrap  = e_wrap;
    e.lerr  = e_lerr;
    e.tc    = e_tc;
    e.wc    = expWc(e_wc);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no edge.
  task automatic resetPulse(input string name);
    exp_t e;
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput({name, ".count"}, int'(count), 0);
    checkOutput({name, ".done"}, int'(done), 0);
    checkOutput({name, ".wrap"}, int'(wrap), 0);
    checkOutput({name, ".load_err"}, int'(load_err), 0);
    checkOutput({name, ".wrap_cnt"}, int'(wrap_cnt), 0);
    checkOutput({name, ".tc"}, int'(tc), 0);
    #1;
    rst_n = 1'b1;
    e.count = 0; e.done = 0; e.wrap = 0; e.lerr = 0; e.tc = 0; e.wc = 0;
    exp_q.push_back(e);
  endtask

  int edge_no = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      edge_no++;
      checkOutput($sformatf("e%0d.count", edge_no), int'(count), e.count);
      checkOutput($sformatf("e%0d.done", edge_no), int'(done), int'(e.done));
      checkOutput($sformatf("e%0d.wrap", edge_no), int'(wrap), int'(e.wrap));
      checkOutput($sformatf("e%0d.load_err", edge_no), int'(load_err), int'(e.lerr));
      checkOutput($sformatf("e%0d.tc", edge_no), int'(tc), int'(e.tc));
      checkOutput($sformatf("e%0d.wrap_cnt", edge_no), int'(wrap_cnt), e.wc);
    end
  end

  initial begin
    rst_n = 1'b0; en = 0; load = 0; load_val = '0; up_dn = 1; one_shot = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.count", int'(count), 0);
    checkOutput("rst.done", int'(done), 0);
    checkOutput("rst.wrap", int'(wrap), 0);
    checkOutput("rst.load_err", int'(load_err), 0);
    checkOutput("rst.wrap_cnt", int'(wrap_cnt), 0);
    rst_n = 1'b1;

    // Three full up wraps: tc at 46, wrap pulse when count returns to 0.
    for (int w = 1; w <= 3; w++) begin
      for (int k = 1; k <= 47; k++) begin
        applyStimulus(1, 0, 0, 1, 0, k % 47, 0, k == 47, 0, k == 46,
                      (k == 47) ? w : w - 1);
      end
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    // Legal load clears the wrap counter.
    applyStimulus(0, 1, 10, 1, 0, 10, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 11, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 12, 0, 0, 0, 0, 0);
    // Illegal load: count holds, en ignored, one-cycle error pulse.
    applyStimulus(1, 1, 50, 1, 0, 12, 0, 0, 1, 0, 0);
    resetPulse("rst_mid");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 50, 1, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 30, 1, 0, 30, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 30, 0, 0, 0, 0, 0);

    // Down wrap from 0 to 46.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 46, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 45, 0, 0, 0, 0, 1);

    // One-shot up: stops at 46, stays there, only load leaves DONE.
    applyStimulus(0, 1, 44, 1, 1, 44, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 45, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 46, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 46, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 1, 1, 46, 1, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 1, 0, 46, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 1, 1, 5, 0, 0, 0, 0, 0);

    // One-shot down stop at 0.
    applyStimulus(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
